// File: rtl/eth_pkg.sv
// Shared types and constants for the per-port Ethernet egress path.
package eth_pkg;

    localparam int DATA_W = 32;

    localparam logic [15:0] PORT_A_ADDR = 16'hABCD;
    localparam logic [15:0] PORT_B_ADDR = 16'hBEEF;

    // Same layout as the switch FIFO word: bit 33 EOP, bit 32 SOP.
    typedef struct packed {
        logic              eop;
        logic              sop;
        logic [DATA_W-1:0] data;
    } buf_word_t;

    typedef enum logic [1:0] {IDLE, RECV, DISCARD} wr_state_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/eth_tx_port_if.sv
// Switch-side word stream and transmit link of one egress port.
interface eth_tx_port_if;
    import eth_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_sop;
    logic              in_eop;
    logic              in_stall;
    logic [DATA_W-1:0] tx_data;
    logic              tx_sop;
    logic              tx_eop;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output in_valid, in_data, in_sop, in_eop, tx_ready,
        input  in_stall, tx_data, tx_sop, tx_eop, tx_valid
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, tx_ready,
        output in_stall, tx_data, tx_sop, tx_eop, tx_valid
    );

endinterface

// File: rtl/eth_pkt_ram.sv
// Packet buffer: simple dual-port RAM with one write port and a registered read port.
module eth_pkt_ram
    import eth_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  buf_word_t     wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output buf_word_t     rdata
);

    buf_word_t mem [DEPTH];
    buf_word_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/eth_tx_port.sv
// Store-and-forward egress stage: validates framing/length, buffers whole packets
// and releases only committed packets onto the valid/ready transmit link.
module eth_tx_port
    import eth_pkg::*;
#(
    parameter int DEPTH         = 64,
    parameter int MAX_PKT_WORDS = 32,
    parameter int MIN_PKT_WORDS = 2
) (
    input  logic         clk,
    input  logic         reset,
    eth_tx_port_if.slave port,
    output logic [15:0]  pkt_count,
    output logic [15:0]  drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = $clog2(MAX_PKT_WORDS + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_P   = PW'(MAX_PKT_WORDS);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_PKT_WORDS);
    localparam logic [LW-1:0] LEN_MIN = LW'(MIN_PKT_WORDS);

    wr_state_t     st_q, st_d;
    logic [PW-1:0] wr_spec_q, wr_spec_d, wr_commit_q, wr_commit_d, rd_q, rd_d;
    logic [PW-1:0] start_base;
    logic [LW-1:0] len_q, len_d;
    logic [15:0]   pkt_count_q, pkt_count_d, drop_count_q, drop_count_d;
    logic          in_stall_q, in_stall_d;
    logic          ram_vld_q, ram_vld_d;
    logic          tx_valid_q, tx_valid_d;
    buf_word_t     tx_word_q, tx_word_d;
    logic [1:0]    drop_inc;
    logic          do_start, pkt_inc, tx_load;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_waddr;
    buf_word_t     ram_wdata, ram_rdata;

    always_comb begin
        st_d        = st_q;
        wr_spec_d   = wr_spec_q;
        wr_commit_d = wr_commit_q;
        len_d       = len_q;
        drop_inc    = '0;
        ram_we      = 1'b0;
        ram_waddr   = wr_spec_q[AW-1:0];
        ram_wdata   = '{eop: port.in_eop, sop: port.in_sop, data: port.in_data};
        start_base  = wr_spec_q;
        do_start    = 1'b0;
        if (port.in_valid) begin
            unique case (st_q)
                IDLE: do_start = port.in_sop;
                RECV: begin
                    if (port.in_sop) begin
                        start_base = wr_commit_q;
                        drop_inc   = 2'd1;
                        do_start   = 1'b1;
                    end else if (((wr_spec_q - rd_q) == DEPTH_P) || (len_q == LEN_MAX)) begin
                        wr_spec_d = wr_commit_q;
                        drop_inc  = 2'd1;
                        st_d      = port.in_eop ? IDLE : DISCARD;
                    end else begin
                        ram_we    = 1'b1;
                        len_d     = len_q + LW'(1);
                        wr_spec_d = wr_spec_q + PW'(1);
                        if (port.in_eop) begin
                            st_d = IDLE;
                            if ((len_q + LW'(1)) >= LEN_MIN) begin
                                wr_commit_d = wr_spec_q + PW'(1);
                            end else begin
                                wr_spec_d = wr_commit_q;
                                drop_inc  = 2'd1;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (port.in_sop)      do_start = 1'b1;
                    else if (port.in_eop) st_d = IDLE;
                end
                default: st_d = IDLE;
            endcase
            // A new SOP into a completely full buffer would overwrite unread
            // committed data, so it is dropped like any other overflow.
            if (do_start) begin
                ram_waddr = start_base[AW-1:0];
                if ((start_base - rd_q) == DEPTH_P) begin
                    wr_spec_d = start_base;
                    drop_inc  = drop_inc + 2'd1;
                    st_d      = port.in_eop ? IDLE : DISCARD;
                end else if (port.in_eop) begin
                    wr_spec_d = start_base;
                    drop_inc  = drop_inc + 2'd1;
                    st_d      = IDLE;
                end else begin
                    ram_we    = 1'b1;
                    wr_spec_d = start_base + PW'(1);
                    len_d     = LW'(1);
                    st_d      = RECV;
                end
            end
        end
    end

    // Two-stage read pipeline: RAM output register, then the tx register.
    always_comb begin
        tx_load    = ram_vld_q && (!tx_valid_q || port.tx_ready);
        ram_re     = (rd_q != wr_commit_q) && (!ram_vld_q || tx_load);
        rd_d       = ram_re ? (rd_q + PW'(1)) : rd_q;
        ram_vld_d  = ram_re ? 1'b1 : (tx_load ? 1'b0 : ram_vld_q);
        tx_valid_d = tx_valid_q;
        tx_word_d  = tx_word_q;
        if (tx_load) begin
            tx_valid_d = 1'b1;
            tx_word_d  = ram_rdata;
        end else if (port.tx_ready) begin
            tx_valid_d = 1'b0;
        end
        pkt_inc      = tx_valid_q && port.tx_ready && tx_word_q.eop;
        pkt_count_d  = sat_add16(pkt_count_q, {1'b0, pkt_inc});
        drop_count_d = sat_add16(drop_count_q, drop_inc);
        in_stall_d   = (DEPTH_P - (wr_spec_d - rd_d)) < MAX_P;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= IDLE;
            wr_spec_q    <= '0;
            wr_commit_q  <= '0;
            rd_q         <= '0;
            len_q        <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
            in_stall_q   <= 1'b0;
            ram_vld_q    <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_word_q    <= '0;
        end else begin
            st_q         <= st_d;
            wr_spec_q    <= wr_spec_d;
            wr_commit_q  <= wr_commit_d;
            rd_q         <= rd_d;
            len_q        <= len_d;
            pkt_count_q  <= pkt_count_d;
            drop_count_q <= drop_count_d;
            in_stall_q   <= in_stall_d;
            ram_vld_q    <= ram_vld_d;
            tx_valid_q   <= tx_valid_d;
            tx_word_q    <= tx_word_d;
        end
    end

    eth_pkt_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    assign port.in_stall = in_stall_q;
    assign port.tx_valid = tx_valid_q;
    assign port.tx_data  = tx_word_q.data;
    assign port.tx_sop   = tx_word_q.sop;
    assign port.tx_eop   = tx_word_q.eop;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;

endmodule

// File: doc/eth_tx_port.md
Name: eth_tx_port

Overview:
Egress stage placed directly downstream of the two-port switch, with one instance per output port (A and B). It takes the switch's per-port word stream (data, SOP, EOP) and validates framing and length. Whole packets are buffered store-and-forward in a local RAM. Only complete, well-formed packets are released onto a valid/ready transmit link, and per-port good and dropped packet counters are maintained.

Parameters:
DATA_W, 32, payload word width
DEPTH, 64, buffer depth in words; power of 2, must be >= 2*MAX_PKT_WORDS
MAX_PKT_WORDS, 32, longest legal packet in words, SOP and EOP words included
MIN_PKT_WORDS, 2, shortest legal packet in words (dest addr word + src addr word)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_data/in_sop/in_eop are valid this cycle
in_data  in  DATA_W  packet word from switch output
in_sop  in  1  first word of packet
in_eop  in  1  last word of packet
in_stall  out  1  upstream must not start a new packet while high
tx_data  out  DATA_W  transmit word
tx_sop  out  1  first word of transmitted packet
tx_eop  out  1  last word of transmitted packet
tx_valid  out  1  tx word present
tx_ready  in  1  link accepts word when tx_valid && tx_ready
pkt_count  out  16  packets fully transmitted, saturating
drop_count  out  16  packets dropped, saturating

Behaviour:
- Reset (async, high): all pointers = 0; write FSM = IDLE; tx_valid = 0, tx_sop = 0, tx_eop = 0, tx_data = 0; in_stall = 0; both counters = 0. A partial packet in the buffer is lost.
- Buffer word = {eop, sop, data}, 34 bits. Pointers are log2(DEPTH)+1 bits with wrap bit. Three pointers:
  - wr_spec: speculative write pointer.
  - wr_commit: end of the last committed packet.
  - rd: read pointer.
- Write FSM states: IDLE, RECV, DISCARD. len = words written to the current packet.
- IDLE:
  - in_valid && in_sop: write the word at wr_spec; len = 1; go to RECV.
  - If in_eop is also set (1-word packet, below MIN): roll back, drop_count++, stay in IDLE.
  - in_valid without in_sop (orphan word): ignore silently.
- RECV, for each in_valid word:
  - If in_sop: abort the current packet (wr_spec <= wr_commit, drop_count++), then treat the word as the start of a new packet per IDLE rules.
  - Else if buffer full (wr_spec - rd == DEPTH) or len == MAX_PKT_WORDS:
    - Roll back, drop_count++.
    - Go to DISCARD, or to IDLE if this word has EOP.
  - Else write the word, len++. If in_eop:
    - len+1 >= MIN_PKT_WORDS: commit (wr_commit <= wr_spec+1), go to IDLE.
    - Otherwise: roll back, drop_count++, go to IDLE.
- DISCARD: drop words until an in_valid && in_eop word, then go to IDLE. An in_sop word in DISCARD restarts reception as in IDLE (no extra drop).
- in_stall (registered): high when free space (DEPTH - (wr_spec - rd)) < MAX_PKT_WORDS. It is advisory; overflow is still handled by the drop rule above.
- Read side:
  - The head word is eligible when rd != wr_commit.
  - Output register: when it is empty, or holds a word being accepted this cycle, load the next eligible word the following cycle. The RAM has registered read, so first-word latency is 2 cycles after commit.
  - tx_valid/tx_data/tx_sop/tx_eop stay stable while tx_valid && !tx_ready.
  - Back-to-back words at full rate when tx_ready stays high.
  - No partial packet is ever presented.
- pkt_count++ on an accepted word with tx_eop.
- Counters saturate at 0xFFFF.
- Simultaneous commit, read, drop and count updates in one cycle are all legal and independent. A drop and a commit never coincide.

Decomposition:
- Package eth_pkg:
  - DATA_W.
  - Buffer word struct {eop, sop, data} using the switch FIFO bit layout: bit 33 EOP, bit 32 SOP.
  - Write-state enum {IDLE, RECV, DISCARD}.
  - Port address constants 'hABCD and 'hBEEF.
- One sub-module, eth_pkt_ram: simple dual-port RAM, DEPTH x 34, one write port, registered read port.

Test Plan:
- 4-word packet [ABCD,1,2,3] with SOP on word 0 and EOP on word 3, tx_ready = 1 -> same 4 words out with SOP/EOP aligned; first tx_valid 2 cycles after the EOP write; pkt_count = 1.
- 1-word packet (SOP+EOP) -> nothing transmitted, drop_count = 1. Then a SOP arriving mid-packet after 2 words -> first packet dropped (drop_count = 2), second packet transmitted intact.
- 33-word packet -> dropped, drop_count = 1, nothing out. A following 32-word packet -> transmitted, pkt_count = 1.
- tx_ready held low while two 8-word packets arrive -> tx_valid = 1 with the first word held stable. Release tx_ready -> 16 words out back-to-back, pkt_count = 2.
- tx_ready low while 32-word packets are sent -> in_stall asserts once free space < 32. Ignoring stall and sending a third 32-word packet -> that packet is dropped and the earlier two are transmitted intact.
- Assert reset mid-RECV and mid-transmit -> all outputs 0 immediately and counters 0. The next packet after reset is transmitted correctly.
